// File: rtl/adc_pkg.sv
// Shared types and defaults for the 12-bit ADC serial sample link.
package adc_pkg;

   localparam int ADC_DATA_W    = 12;
   localparam int ADC_LEAD_BITS = 1;

   typedef enum logic [1:0] {RESP_IDLE, RESP_LEAD, RESP_SHIFT, RESP_TAIL} resp_state_t;

   typedef logic [ADC_DATA_W-1:0] adc_sample_t;

endpackage

// File: rtl/adc_sample_buf.sv
// One-entry valid/ready holding register; take_i empties it unless a push lands in the same cycle.
module adc_sample_buf
   import adc_pkg::*;
#(
   parameter int DATA_W = ADC_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              take_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o
);

   logic [DATA_W-1:0] dataQ_q, dataQ_d;
   logic              full_q, full_d;

   assign ready_o = !full_q;
   assign data_o  = dataQ_q;
   assign full_o  = full_q;

   always_comb begin
      dataQ_d = dataQ_q;
      full_d  = full_q;
      if (valid_i && ready_o) begin
         dataQ_d = data_i;
         full_d  = 1'b1;
      end else if (take_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dataQ_q <= '0;
         full_q  <= 1'b0;
      end else begin
         dataQ_q <= dataQ_d;
         full_q  <= full_d;
      end
   end

endmodule

// File: rtl/adc_spi_responder.sv
// ADC-side serialiser: one buffered sample per cs_n frame, MSB-first after LEAD_BITS zeros.
// Optional underrun counter port enabled by defining ADC_RESP_UNDERRUN_CNT_EN.
module adc_spi_responder
   import adc_pkg::*;
#(
   parameter int DATA_W    = ADC_DATA_W,
   parameter int LEAD_BITS = ADC_LEAD_BITS
) (
   input  logic              sck,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sample_i,
   input  logic              sample_valid_i,
   output logic              sample_ready_o,
   input  logic              cs_n,
   output logic              sdo,
   output logic              sdo_en,
   output logic              frame_done_o,
   output logic              underrun_o
`ifdef ADC_RESP_UNDERRUN_CNT_EN
   ,
   output logic [15:0]       underrun_cnt_o
`endif
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] LAST_LEAD = CNT_W'((LEAD_BITS > 0) ? (LEAD_BITS - 1) : 0);

   resp_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] src_q, src_d;
   logic [DATA_W-1:0] lastSent_q, lastSent_d;
   logic              underrun_q, underrun_d;
   logic [DATA_W-1:0] bufData;
   logic              bufFull;
   logic              take;

   adc_sample_buf #(.DATA_W(DATA_W)) u_buf (
      .clk_i   (sck),
      .rst_ni  (rst_n),
      .data_i  (sample_i),
      .valid_i (sample_valid_i),
      .ready_o (sample_ready_o),
      .take_i  (take),
      .data_o  (bufData),
      .full_o  (bufFull)
   );

   // src_q remembers what this frame loaded so a completed frame can refresh lastSent_q.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      src_d      = src_q;
      lastSent_d = lastSent_q;
      underrun_d = 1'b0;
      take       = 1'b0;
      unique case (state_q)
         RESP_IDLE: begin
            if (!cs_n) begin
               take  = 1'b1;
               cnt_d = '0;
               if (bufFull) begin
                  shreg_d = bufData;
                  src_d   = bufData;
               end else begin
                  shreg_d    = lastSent_q;
                  src_d      = lastSent_q;
                  underrun_d = 1'b1;
               end
               state_d = (LEAD_BITS == 0) ? RESP_SHIFT : RESP_LEAD;
            end
         end
         RESP_LEAD: begin
            if (cs_n) begin
               state_d = RESP_IDLE;
            end else if (cnt_q == LAST_LEAD) begin
               cnt_d   = '0;
               state_d = RESP_SHIFT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP_SHIFT: begin
            if (cs_n) begin
               state_d = RESP_IDLE;
            end else if (cnt_q == LAST_BIT) begin
               state_d    = RESP_TAIL;
               lastSent_d = src_q;
            end else begin
               shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         RESP_TAIL: begin
            if (cs_n) state_d = RESP_IDLE;
         end
         default: state_d = RESP_IDLE;
      endcase
   end

   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RESP_IDLE;
         cnt_q      <= '0;
         shreg_q    <= '0;
         src_q      <= '0;
         lastSent_q <= '0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         src_q      <= src_d;
         lastSent_q <= lastSent_d;
         underrun_q <= underrun_d;
      end
   end

   assign sdo          = (state_q == RESP_SHIFT) && shreg_q[DATA_W-1];
   assign sdo_en       = (state_q != RESP_IDLE);
   assign frame_done_o = (state_q == RESP_SHIFT) && (cnt_q == LAST_BIT);
   assign underrun_o   = underrun_q;

`ifdef ADC_RESP_UNDERRUN_CNT_EN
   logic [15:0] underrunCnt_q;

   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         underrunCnt_q <= '0;
      end else if (underrun_d && (underrunCnt_q != 16'hFFFF)) begin
         underrunCnt_q <= underrunCnt_q + 16'd1;
      end
   end

   assign underrun_cnt_o = underrunCnt_q;
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: frames, underrun, buffering, abort, reset, push/frame race.
module tb_adc_spi_responder;

   logic        sck = 1'b0;
   logic        rst_n;
   logic [11:0] sample_i;
   logic        sample_valid_i;
   logic        sample_ready_o;
   logic        cs_n;
   logic        sdo;
   logic        sdo_en;
   logic        frame_done_o;
   logic        underrun_o;
`ifdef ADC_RESP_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt_o;
`endif

   int checks   = 0;
   int failures = 0;

   adc_spi_responder dut (
      .sck            (sck),
      .rst_n          (rst_n),
      .sample_i       (sample_i),
      .sample_valid_i (sample_valid_i),
      .sample_ready_o (sample_ready_o),
      .cs_n           (cs_n),
      .sdo            (sdo),
      .sdo_en         (sdo_en),
      .frame_done_o   (frame_done_o),
      .underrun_o     (underrun_o)
`ifdef ADC_RESP_UNDERRUN_CNT_EN
      ,
      .underrun_cnt_o (underrun_cnt_o)
`endif
   );

   always #5 sck = ~sck;

   task automatic tick();
      @(posedge sck);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pushSample(input logic [11:0] val);
      sample_i       = val;
      sample_valid_i = 1'b1;
      checkOutput("readyBeforePush", 16'(sample_ready_o), 16'd1);
      tick();
      sample_valid_i = 1'b0;
      checkOutput("readyAfterPush", 16'(sample_ready_o), 16'd0);
   endtask

   // One frame: cs_n low for the lead bit plus nBits data bits; nBits==12 completes, fewer aborts.
   task automatic applyStimulus(input logic [11:0] expWord, input logic expUnder,
                                input int pushAt, input logic [11:0] pushVal, input int nBits);
      logic [11:0] got;
      int          doneCnt;
      got     = '0;
      doneCnt = 0;
      cs_n    = 1'b0;
      tick();
      sample_valid_i = 1'b0;
      checkOutput("underrunPulse", 16'(underrun_o), 16'(expUnder));
      checkOutput("leadEnable", 16'(sdo_en), 16'd1);
      checkOutput("leadZero", 16'(sdo), 16'd0);
      for (int i = 0; i < nBits; i++) begin
         if (i == pushAt) begin
            checkOutput("readyInFrame", 16'(sample_ready_o), 16'd1);
            sample_i       = pushVal;
            sample_valid_i = 1'b1;
         end
         tick();
         sample_valid_i = 1'b0;
         if (i == 0) checkOutput("underrunOneCycle", 16'(underrun_o), 16'd0);
         got = {got[10:0], sdo};
         if (frame_done_o) doneCnt++;
      end
      if (nBits == 12) begin
         checkOutput("frameWord", 16'(got), 16'(expWord));
         checkOutput("doneOnLsb", 16'(frame_done_o), 16'd1);
         checkOutput("doneOnce", 16'(doneCnt), 16'd1);
         tick();
         checkOutput("tailEnable", 16'(sdo_en), 16'd1);
         checkOutput("tailZero", 16'(sdo), 16'd0);
         checkOutput("tailNoDone", 16'(frame_done_o), 16'd0);
         cs_n = 1'b1;
         tick();
         checkOutput("idleEnable", 16'(sdo_en), 16'd0);
      end else begin
         checkOutput("partialWord", 16'(got), 16'(expWord >> (12 - nBits)));
         cs_n = 1'b1;
         tick();
         checkOutput("abortEnable", 16'(sdo_en), 16'd0);
         checkOutput("abortNoDone", 16'(doneCnt + int'(frame_done_o)), 16'd0);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      cs_n           = 1'b1;
      sample_i       = '0;
      sample_valid_i = 1'b0;
      #3;
      checkOutput("rstSdo", 16'(sdo), 16'd0);
      checkOutput("rstSdoEn", 16'(sdo_en), 16'd0);
      checkOutput("rstDone", 16'(frame_done_o), 16'd0);
      checkOutput("rstUnderrun", 16'(underrun_o), 16'd0);
      checkOutput("rstReady", 16'(sample_ready_o), 16'd1);
`ifdef ADC_RESP_UNDERRUN_CNT_EN
      checkOutput("rstUnderrunCnt", underrun_cnt_o, 16'd0);
`endif
      #4 rst_n = 1'b1;
      tick();

      // 1: basic frame
      pushSample(12'h48F);
      applyStimulus(12'h48F, 1'b0, -1, 12'h000, 12);
      checkOutput("readyAfterFrame1", 16'(sample_ready_o), 16'd1);

      // 2: underrun resends last sample
      applyStimulus(12'h48F, 1'b1, -1, 12'h000, 12);

      // 3: push during a frame, second push held until buffer drains
      applyStimulus(12'h48F, 1'b1, 3, 12'hA5C, 12);
      sample_i       = 12'h3F0;
      sample_valid_i = 1'b1;
      tick();
      checkOutput("heldNotReady", 16'(sample_ready_o), 16'd0);
      applyStimulus(12'hA5C, 1'b0, 0, 12'h3F0, 12);
      checkOutput("heldAccepted", 16'(sample_ready_o), 16'd0);
      applyStimulus(12'h3F0, 1'b0, -1, 12'h000, 12);

      // 4: abort after 5 bits; last_sent keeps 12'h3F0
      pushSample(12'hFFF);
      applyStimulus(12'hFFF, 1'b0, -1, 12'h000, 5);
      applyStimulus(12'h3F0, 1'b1, -1, 12'h000, 12);
`ifdef ADC_RESP_UNDERRUN_CNT_EN
      checkOutput("underrunCnt3", underrun_cnt_o, 16'd3);
`endif

      // 5: async reset mid-SHIFT with the buffer full
      pushSample(12'h7E1);
      cs_n = 1'b0;
      tick();
      sample_i       = 12'h111;
      sample_valid_i = 1'b1;
      tick();
      sample_valid_i = 1'b0;
      tick();
      tick();
      checkOutput("midShiftEnable", 16'(sdo_en), 16'd1);
      checkOutput("midShiftFull", 16'(sample_ready_o), 16'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncSdo", 16'(sdo), 16'd0);
      checkOutput("asyncSdoEn", 16'(sdo_en), 16'd0);
      checkOutput("asyncReady", 16'(sample_ready_o), 16'd1);
`ifdef ADC_RESP_UNDERRUN_CNT_EN
      checkOutput("asyncUnderrunCnt", underrun_cnt_o, 16'd0);
`endif
      cs_n = 1'b1;
      #1 rst_n = 1'b1;
      tick();
      applyStimulus(12'h000, 1'b1, -1, 12'h000, 12);

      // 6: push coincides with frame start on an empty buffer
      sample_i       = 12'h2C3;
      sample_valid_i = 1'b1;
      applyStimulus(12'h000, 1'b1, -1, 12'h000, 12);
      checkOutput("racePushStored", 16'(sample_ready_o), 16'd0);
      applyStimulus(12'h2C3, 1'b0, -1, 12'h000, 12);
`ifdef ADC_RESP_UNDERRUN_CNT_EN
      checkOutput("underrunCnt2", underrun_cnt_o, 16'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
